uart_core_cfg: RTL
==================

# uart_core_cfg

Parametrised full-duplex UART core, the next generation of the fixed 8N1 transmitter/receiver pair. It has a runtime-programmable baud divisor, configurable data width, and runtime-selectable parity and stop bits. The receiver uses 16x oversampling and reports parity, framing and overrun errors. An internal loopback mode is provided. It sits between a host register interface and the serial pins.

## Interface
Parameters:
- DATA_BITS, 8, payload bits per frame, legal 5..9
- DIV_W, 16, width of the baud divisor input

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- baud_div  in  DIV_W  clk cycles per oversample tick; 0 is treated as 1
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 reserved (treated as none)
- two_stop  in  1  1 = two stop bits on TX; RX always checks the first stop bit only
- loopback  in  1  1 = RX input taken from internal TX output; tx pin held 1
- tx_data  in  DATA_BITS  byte to send
- wr_en  in  1  write strobe; accepted only when busy=0
- busy  out  1  TX frame in progress
- tx  out  1  serial output, idle high
- rx  in  1  serial input, asynchronous to clk
- rx_data  out  DATA_BITS  last received payload
- rdy  out  1  rx_data valid
- rdy_clr  in  1  clears rdy and all error flags
- parity_err  out  1  parity mismatch on the frame that set rdy
- frame_err  out  1  stop bit sampled 0
- overrun  out  1  a frame completed while rdy was still 1

## Operation
- Tick generator: a counter runs 0..max(baud_div,1)-1 and emits a one-cycle os_tick on wrap. One bit time is 16 os_ticks.
- TX FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- On wr_en with busy=0, TX latches tx_data, parity_mode and two_stop. busy rises the next cycle, and tx drives the start bit (0) on the next os_tick.
- TX sends data LSB first, then parity if enabled, then stop bit(s) at 1.
- Parity: even mode sends the XOR of the data bits; odd mode sends its inverse.
- wr_en while busy=1 is ignored. Config changes during a TX frame have no effect on that frame.
- RX input path: rx passes through a 2-flop synchronizer, then the loopback mux.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
- RX start detect: a 1→0 transition in IDLE resets the oversample count. The line is re-sampled at count 7.
  - If it is 1, this is a false start: return to IDLE.
  - Otherwise each following bit is sampled after a further 16 ticks, at mid-bit.
- RX uses the live parity_mode. Config must be stable while a frame is being received.
- At the stop sample, the frame is complete:
  - If rdy=0 (or rdy_clr is asserted the same cycle): rx_data is loaded, rdy=1, and parity_err/frame_err are set from this frame.
  - If rdy=1 and rdy_clr=0: rx_data is kept unchanged, overrun=1, and the new frame's errors are discarded.
- A completing frame wins over rdy_clr in the same cycle: rdy stays 1 and overrun is not set.
- After a frame_err, RX waits for the line to return to 1 before re-arming start detection.

## Timing
- Reset values: tx=1, busy=0, rdy=0, rx_data=0, parity_err=0, frame_err=0, overrun=0. All FSMs go to IDLE and the tick counter goes to 0.
- An rst assertion mid-frame aborts immediately. tx returns to 1 asynchronously, and no partial data is delivered.
- TX frame length is (1 + DATA_BITS + P + S) × 16 × max(baud_div,1) clk cycles, where P = 1 if parity is on, and S = 1 or 2 stop bits.
  - busy deasserts on the os_tick that ends the last stop bit.
  - A back-to-back wr_en in that cycle is not accepted; it is accepted from the next cycle.
- RX latency: rdy rises 1 clk after the stop-bit mid-sample. That is about 2 clk of synchronizer delay plus 8 ticks after the stop bit's start edge.
- rdy_clr takes effect on the next clk edge.

## Structure
- Package uart_cfg_pkg holds:
  - parity mode constants: PAR_NONE, PAR_EVEN, PAR_ODD
  - TX and RX state enums
  - OVERSAMPLE=16 and SAMPLE_MID=7
- Sub-modules:
  - uart_tick_gen: runtime divisor to os_tick.
  - TX and RX FSMs: may be separate sub-modules, or live in the core.

## Test plan
- 8N1 loopback, baud_div=4, send 0xA5:
  - busy high for exactly 640 clk.
  - rdy=1 with rx_data=0xA5, no errors.
- Even parity, two_stop=1, send 0x07:
  - tx shows parity bit 1 and two stop bits.
  - Frame is 768 clk at baud_div=4.
  - Looped-back rx_data=0x07, parity_err=0.
- External rx with odd parity selected, 0x3C sent with the wrong parity bit: rdy=1, rx_data=0x3C, parity_err=1.
- External rx, 0x55 with stop bit 0: frame_err=1. RX only re-arms after the line returns high.
- Two frames 0x11 then 0x22 with no rdy_clr: rx_data=0x11, overrun=1. rdy_clr then clears rdy and overrun.
- rx pulsed low for 4 clk at baud_div=4 (false start): no rdy. Separately, rst asserted mid-TX: tx=1 and busy=0 immediately.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared constants, state encodings and config helpers for the configurable UART core.
package uart_cfg_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 7;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Mode 3 is reserved and behaves as no parity.
    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle os_tick every max(baud_div,1) clocks.
module uart_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] baud_div,
    output logic             os_tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    assign last    = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    // >= keeps the counter from running the long way round if baud_div shrinks mid-count.
    assign os_tick = (cnt >= last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || os_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_core_cfg.sv
// Full-duplex UART with runtime divisor, parity and stop-bit selection, 16x RX oversampling
// and internal loopback.
module uart_core_cfg
    import uart_cfg_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 loopback,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 wr_en,
    output logic                 busy,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    input  logic                 rdy_clr,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID      = 4'(SAMPLE_MID);
    localparam logic [3:0] IDX_LAST = 4'(DATA_BITS - 1);

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic [1:0] mode);
        return (^d) ^ (mode == PAR_ODD);
    endfunction

    // ---------------- transmitter ----------------
    tx_state_t            tx_state;
    logic [3:0]           tx_cnt;
    logic [3:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic [1:0]           tx_mode;
    logic                 tx_two_stop;
    logic                 tx_line;
    logic                 tx_accept;
    logic                 tx_tick;
    logic                 tx_bit_end;
    logic                 tx_load_bit;

    assign tx_accept = wr_en && !busy;

    // Restarting the TX divider on accept makes the frame length independent of write phase.
    uart_tick_gen #(.DIV_W(DIV_W)) u_tx_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (tx_accept),
        .baud_div (baud_div),
        .os_tick  (tx_tick)
    );

    assign tx_bit_end  = tx_tick && (tx_cnt == BIT_LAST);
    assign tx_load_bit = tx_bit_end &&
                         ((tx_state == TX_START) || (tx_state == TX_DATA && tx_idx != IDX_LAST));

    always_ff @(posedge clk) begin
        if (tx_accept) begin
            tx_shift <= tx_data;
            tx_par   <= parity_bit(tx_data, parity_mode);
        end else if (tx_load_bit) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_mode     <= PAR_NONE;
            tx_two_stop <= 1'b0;
            tx_line     <= 1'b1;
            busy        <= 1'b0;
        end else begin
            if (tx_tick && tx_state != TX_IDLE) begin
                tx_cnt <= tx_cnt + 4'd1;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (tx_accept) begin
                        tx_state    <= TX_START;
                        tx_cnt      <= '0;
                        tx_mode     <= parity_mode;
                        tx_two_stop <= two_stop;
                        busy        <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_DATA;
                        tx_idx   <= '0;
                        tx_line  <= tx_shift[0];
                    end else if (tx_tick) begin
                        tx_line <= 1'b0;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_idx == IDX_LAST) begin
                            if (parity_on(tx_mode)) begin
                                tx_state <= TX_PARITY;
                                tx_line  <= tx_par;
                            end else begin
                                tx_state <= TX_STOP1;
                                tx_line  <= 1'b1;
                            end
                        end else begin
                            tx_idx  <= tx_idx + 4'd1;
                            tx_line <= tx_shift[0];
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_STOP1;
                        tx_line  <= 1'b1;
                    end
                end
                TX_STOP1: begin
                    if (tx_bit_end) begin
                        if (tx_two_stop) begin
                            tx_state <= TX_STOP2;
                        end else begin
                            tx_state <= TX_IDLE;
                            busy     <= 1'b0;
                        end
                    end
                end
                TX_STOP2: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_line  <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign tx = loopback ? 1'b1 : tx_line;

    // ---------------- receiver ----------------
    rx_state_t            rx_state;
    logic [3:0]           rx_cnt;
    logic [3:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 rx_in;
    logic                 rx_tick;
    logic                 rx_bit_end;
    logic                 rx_done;
    logic                 rx_par_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_in;
        end
    end

    assign rx_in = loopback ? tx_line : rx_sync;

    uart_tick_gen #(.DIV_W(DIV_W)) u_rx_tick (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .baud_div (baud_div),
        .os_tick  (rx_tick)
    );

    assign rx_bit_end = rx_tick && (rx_cnt == BIT_LAST);
    assign rx_done    = (rx_state == RX_STOP) && rx_bit_end;

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_bit_end) begin
            rx_shift <= {rx_in, rx_shift[DATA_BITS-1:1]};
        end
    end

    // Start detection needs a 1->0 edge, so a line stuck low after a framing error cannot re-arm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_par_bad <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_in) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_cnt == MID) begin
                            rx_cnt <= '0;
                            if (rx_in) begin
                                rx_state <= RX_IDLE;
                            end else begin
                                rx_state   <= RX_DATA;
                                rx_idx     <= '0;
                                rx_par_bad <= 1'b0;
                            end
                        end else begin
                            rx_cnt <= rx_cnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == BIT_LAST) begin
                            if (rx_idx == IDX_LAST) begin
                                rx_state <= parity_on(parity_mode) ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_idx <= rx_idx + 4'd1;
                            end
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_tick) begin
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == BIT_LAST) begin
                            rx_par_bad <= (rx_in != parity_bit(rx_shift, parity_mode));
                            rx_state   <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == BIT_LAST) begin
                            rx_state <= RX_IDLE;
                        end
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                    rx_cnt   <= '0;
                end
            endcase
        end
    end

    // A completing frame takes priority over rdy_clr in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (rx_done) begin
            if (!rdy || rdy_clr) begin
                rx_data    <= rx_shift;
                rdy        <= 1'b1;
                parity_err <= rx_par_bad;
                frame_err  <= !rx_in;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rdy_clr) begin
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule
